// File: rtl/battleship_pkg.sv
// Shared definitions for the battleship game: grid geometry, coordinate type,
// cursor FSM states and button indexing.
package battleship_pkg;

  localparam int unsigned GRID_SIZE = 10;
  localparam int unsigned COORD_W   = 4;

  typedef logic [COORD_W-1:0] coord_t;

  typedef enum logic [1:0] {
    CurIdle   = 2'd0,
    CurHold   = 2'd1,
    CurRepeat = 2'd2
  } cursor_state_t;

  typedef enum logic [1:0] {
    DirUp    = 2'd0,
    DirDown  = 2'd1,
    DirLeft  = 2'd2,
    DirRight = 2'd3
  } dir_t;

  localparam int unsigned BTN_U = 0;
  localparam int unsigned BTN_D = 1;
  localparam int unsigned BTN_L = 2;
  localparam int unsigned BTN_R = 3;
  localparam int unsigned BTN_C = 4;
  localparam int unsigned NUM_BTNS = 5;

  function automatic coord_t coord_inc(coord_t c);
    return (c >= coord_t'(GRID_SIZE - 1)) ? '0 : c + coord_t'(1);
  endfunction

  // Out-of-range values also land on the last cell so the cursor can never escape.
  function automatic coord_t coord_dec(coord_t c);
    return ((c == '0) || (c >= coord_t'(GRID_SIZE))) ? coord_t'(GRID_SIZE - 1)
                                                      : c - coord_t'(1);
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// One push button: 2-flop synchronizer, counting debouncer and rising-edge
// press detector.
module btn_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_raw,
  output logic level,
  output logic press
);

  localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q, sync2_q;
  logic             level_q, level_d;
  logic             prev_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      prev_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= btn_raw;
      sync2_q <= sync1_q;
      level_q <= level_d;
      prev_q  <= level_q;
      cnt_q   <= cnt_d;
    end
  end

  // Any cycle where the synchronized input agrees with the level restarts the count.
  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    if (sync2_q != level_q) begin
      if (cnt_q >= CNT_LAST) begin
        level_d = sync2_q;
      end else if (cnt_q != '1) begin
        cnt_d = cnt_q + CNT_W'(1);
      end else begin
        cnt_d = cnt_q;
      end
    end
  end

  assign level = level_q;
  assign press = level_q & ~prev_q;

endmodule

// File: rtl/cursor_ctrl.sv
// Cursor controller: debounced direction buttons move a 10x10 grid cursor with
// hold-to-repeat, and the centre button issues a single-cycle fire request.
module cursor_ctrl
  import battleship_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned REPEAT_DELAY    = 50000000,
  parameter int unsigned REPEAT_RATE     = 15000000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               btn_u,
  input  logic               btn_d,
  input  logic               btn_l,
  input  logic               btn_r,
  input  logic               btn_c,
  input  logic               game_over,
  output logic [COORD_W-1:0] sprite_row,
  output logic [COORD_W-1:0] sprite_col,
  output logic               fire
);

  localparam int unsigned REP_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int unsigned REP_W   = (REP_MAX > 1) ? $clog2(REP_MAX) : 1;
  localparam logic [REP_W-1:0] DELAY_LAST = REP_W'(REPEAT_DELAY - 1);
  localparam logic [REP_W-1:0] RATE_LAST  = REP_W'(REPEAT_RATE - 1);

  logic [NUM_BTNS-1:0] btn_raw, btn_level, btn_press;

  assign btn_raw = {btn_c, btn_r, btn_l, btn_d, btn_u};

  for (genvar i = 0; i < NUM_BTNS; i++) begin : g_btn
    btn_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_btn (
      .clk    (clk),
      .reset  (reset),
      .btn_raw(btn_raw[i]),
      .level  (btn_level[i]),
      .press  (btn_press[i])
    );
  end

  // The fire button is edge-only; its level has no consumer.
  logic unused_c_level;
  assign unused_c_level = btn_level[BTN_C];

  cursor_state_t state_q, state_d;
  dir_t          dir_q, dir_d;
  logic [REP_W-1:0] rep_cnt_q, rep_cnt_d, rep_inc;
  coord_t        row_q, row_d, col_q, col_d;
  logic          fire_q, fire_d;

  logic any_press, held_level, move_en;
  dir_t press_dir, move_dir;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= CurIdle;
      dir_q     <= DirUp;
      rep_cnt_q <= '0;
      row_q     <= '0;
      col_q     <= '0;
      fire_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      dir_q     <= dir_d;
      rep_cnt_q <= rep_cnt_d;
      row_q     <= row_d;
      col_q     <= col_d;
      fire_q    <= fire_d;
    end
  end

  always_comb begin
    any_press = |btn_press[BTN_R:BTN_U];
    press_dir = DirUp;
    if (btn_press[BTN_U])      press_dir = DirUp;
    else if (btn_press[BTN_D]) press_dir = DirDown;
    else if (btn_press[BTN_L]) press_dir = DirLeft;
    else if (btn_press[BTN_R]) press_dir = DirRight;

    held_level = 1'b0;
    unique case (dir_q)
      DirUp:    held_level = btn_level[BTN_U];
      DirDown:  held_level = btn_level[BTN_D];
      DirLeft:  held_level = btn_level[BTN_L];
      DirRight: held_level = btn_level[BTN_R];
      default:  held_level = 1'b0;
    endcase

    rep_inc = (rep_cnt_q == '1) ? rep_cnt_q : rep_cnt_q + REP_W'(1);
  end

  always_comb begin
    state_d   = state_q;
    dir_d     = dir_q;
    rep_cnt_d = rep_inc;
    move_en   = 1'b0;
    move_dir  = dir_q;
    fire_d    = btn_press[BTN_C] & ~game_over;

    if (game_over) begin
      state_d   = CurIdle;
      rep_cnt_d = '0;
    end else if (any_press && ((state_q == CurIdle) || (press_dir != dir_q))) begin
      // A fresh press always wins over the hold/repeat timing of the old direction.
      move_en   = 1'b1;
      move_dir  = press_dir;
      dir_d     = press_dir;
      rep_cnt_d = '0;
      state_d   = CurHold;
    end else begin
      unique case (state_q)
        CurIdle: begin
          rep_cnt_d = '0;
        end
        CurHold: begin
          if (!held_level) begin
            state_d   = CurIdle;
            rep_cnt_d = '0;
          end else if (rep_cnt_q >= DELAY_LAST) begin
            move_en   = 1'b1;
            rep_cnt_d = '0;
            state_d   = CurRepeat;
          end
        end
        CurRepeat: begin
          if (!held_level) begin
            state_d   = CurIdle;
            rep_cnt_d = '0;
          end else if (rep_cnt_q >= RATE_LAST) begin
            move_en   = 1'b1;
            rep_cnt_d = '0;
          end
        end
        default: begin
          state_d   = CurIdle;
          rep_cnt_d = '0;
        end
      endcase
    end
  end

  always_comb begin
    row_d = row_q;
    col_d = col_q;
    if (move_en) begin
      unique case (move_dir)
        DirUp:    row_d = coord_dec(row_q);
        DirDown:  row_d = coord_inc(row_q);
        DirLeft:  col_d = coord_dec(col_q);
        DirRight: col_d = coord_inc(col_q);
        default:  row_d = row_q;
      endcase
    end
  end

  assign sprite_row = row_q;
  assign sprite_col = col_q;
  assign fire       = fire_q;

endmodule

// File: tb/tb_cursor_ctrl.sv
// Self-checking bench for cursor_ctrl: directed scenarios plus randomized
// button traffic compared cycle by cycle against a behavioural model.
module tb_cursor_ctrl;
  import battleship_pkg::*;

  localparam int unsigned DB = 4;
  localparam int unsigned RD = 20;
  localparam int unsigned RR = 5;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       btn_u = 1'b0, btn_d = 1'b0, btn_l = 1'b0, btn_r = 1'b0, btn_c = 1'b0;
  logic       game_over = 1'b0;
  logic [3:0] sprite_row, sprite_col;
  logic       fire;

  int n_checks = 0;
  int n_errors = 0;

  cursor_ctrl #(
    .DEBOUNCE_CYCLES(DB),
    .REPEAT_DELAY   (RD),
    .REPEAT_RATE    (RR)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .btn_u     (btn_u),
    .btn_d     (btn_d),
    .btn_l     (btn_l),
    .btn_r     (btn_r),
    .btn_c     (btn_c),
    .game_over (game_over),
    .sprite_row(sprite_row),
    .sprite_col(sprite_col),
    .fire      (fire)
  );

  always #5 clk = ~clk;

  // Behavioural model. Button bit order: 0 up, 1 down, 2 left, 3 right, 4 centre.
  logic [4:0] hist[$];
  logic [4:0] m_level = '0, m_prev = '0;
  int         m_age[5];
  int         m_row = 0, m_col = 0, m_dir = -1, m_since = 0;
  bit         m_rep = 1'b0;
  logic       m_fire = 1'b0;

  task automatic model_move(input int d);
    case (d)
      0:       m_row = (m_row + 9) % 10;
      1:       m_row = (m_row + 1) % 10;
      2:       m_col = (m_col + 9) % 10;
      default: m_col = (m_col + 1) % 10;
    endcase
  endtask

  task automatic model_reset();
    hist.delete();
    repeat (DB + 2) hist.push_back(5'b0);
    m_level = '0;
    m_prev  = '0;
    for (int b = 0; b < 5; b++) m_age[b] = 0;
    m_row = 0; m_col = 0; m_dir = -1; m_since = 0; m_rep = 1'b0; m_fire = 1'b0;
  endtask

  // A level flips once the last DB synchronized samples all disagree with it
  // and at least DB cycles have passed since it last flipped.
  task automatic model_step();
    logic [4:0] raw, ev, h;
    int p;
    bit all_diff;
    if (reset) begin
      model_reset();
      return;
    end
    raw = {btn_c, btn_r, btn_l, btn_d, btn_u};
    ev  = m_level & ~m_prev;
    m_fire = ev[4] & ~game_over;
    if (game_over) begin
      m_dir = -1;
    end else begin
      p = -1;
      for (int i = 3; i >= 0; i--) if (ev[i]) p = i;
      if (p >= 0 && p != m_dir) begin
        model_move(p); m_dir = p; m_rep = 1'b0; m_since = 0;
      end else if (m_dir >= 0) begin
        if (!m_level[m_dir]) m_dir = -1;
        else begin
          m_since++;
          if (m_since == (m_rep ? int'(RR) : int'(RD))) begin
            model_move(m_dir); m_rep = 1'b1; m_since = 0;
          end
        end
      end
    end
    m_prev = m_level;
    for (int b = 0; b < 5; b++) begin
      m_age[b]++;
      all_diff = 1'b1;
      for (int k = 1; k <= int'(DB); k++) begin
        h = hist[hist.size() - 1 - k];
        if (h[b] == m_level[b]) all_diff = 1'b0;
      end
      if (all_diff && m_age[b] >= int'(DB)) begin
        m_level[b] = ~m_level[b];
        m_age[b]   = 0;
      end
    end
    hist.push_back(raw);
    if (hist.size() > 16) void'(hist.pop_front());
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk);
      model_step();
    end
  end

  task automatic drive_btns(input logic [4:0] v);
    {btn_c, btn_r, btn_l, btn_d, btn_u} = v;
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press_release(input logic [4:0] v, input int hold, input int gap);
    drive_btns(v);
    step(hold);
    drive_btns(5'b0);
    step(gap);
  endtask

  task automatic test_reset();
    reset = 1'b1; game_over = 1'b0; drive_btns(5'b0);
    step(3);
    n_checks++;
    if (sprite_row !== 4'd0 || sprite_col !== 4'd0 || fire !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_outputs: got row=%0d col=%0d fire=%b, want 0 0 0",
               sprite_row, sprite_col, fire);
    end
    n_checks++;
    if (dut.state_q !== CurIdle) begin
      n_errors++;
      $display("FAIL reset_fsm: got state=%0d, want %0d", dut.state_q, CurIdle);
    end
    reset = 1'b0;
    step(3);
    n_checks++;
    if (sprite_row !== 4'd0 || sprite_col !== 4'd0 || fire !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_idle: got row=%0d col=%0d fire=%b, want 0 0 0",
               sprite_row, sprite_col, fire);
    end
  endtask

  task automatic test_clean_press();
    int exp_col;
    drive_btns(5'b01000);
    for (int k = 1; k <= 12; k++) begin
      step(1);
      exp_col = (k >= 7) ? 1 : 0;
      n_checks++;
      if (sprite_col !== 4'(exp_col) || sprite_row !== 4'd0) begin
        n_errors++;
        $display("FAIL clean_press k=%0d: got row=%0d col=%0d, want 0 %0d",
                 k, sprite_row, sprite_col, exp_col);
      end
      if (k == 10) drive_btns(5'b0);
    end
    step(12);
  endtask

  task automatic test_bounce();
    int exp_col;
    for (int i = 0; i < 4; i++) begin
      drive_btns((i % 2 == 0) ? 5'b01000 : 5'b00000);
      step(2);
    end
    n_checks++;
    if (sprite_col !== 4'd1) begin
      n_errors++;
      $display("FAIL bounce_ignored: got col=%0d, want 1", sprite_col);
    end
    drive_btns(5'b01000);
    for (int k = 1; k <= 14; k++) begin
      step(1);
      exp_col = (k >= 7) ? 2 : 1;
      n_checks++;
      if (sprite_col !== 4'(exp_col) || sprite_col !== 4'(m_col)) begin
        n_errors++;
        $display("FAIL bounce k=%0d: got col=%0d, want %0d (model %0d)",
                 k, sprite_col, exp_col, m_col);
      end
    end
    drive_btns(5'b0);
    step(14);
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 7; i++) press_release(5'b01000, 8, 12);
    n_checks++;
    if (sprite_row !== 4'd0 || sprite_col !== 4'd9) begin
      n_errors++;
      $display("FAIL wrap_setup: got (%0d,%0d), want (0,9)", sprite_row, sprite_col);
    end
    press_release(5'b01000, 8, 12);
    n_checks++;
    if (sprite_row !== 4'd0 || sprite_col !== 4'd0) begin
      n_errors++;
      $display("FAIL wrap_col: got (%0d,%0d), want (0,0)", sprite_row, sprite_col);
    end
    press_release(5'b00001, 8, 12);
    n_checks++;
    if (sprite_row !== 4'd9 || sprite_col !== 4'd0) begin
      n_errors++;
      $display("FAIL wrap_row: got (%0d,%0d), want (9,0)", sprite_row, sprite_col);
    end
  endtask

  task automatic test_repeat();
    int move_t[5] = '{7, 27, 32, 37, 42};
    int start_row, moves, exp_row;
    start_row = m_row;
    drive_btns(5'b00010);
    for (int k = 1; k <= 52; k++) begin
      step(1);
      moves = 0;
      foreach (move_t[i]) if (k >= move_t[i]) moves++;
      exp_row = (start_row + moves) % 10;
      n_checks++;
      if (sprite_row !== 4'(exp_row) || sprite_row !== 4'(m_row) || sprite_col !== 4'd0) begin
        n_errors++;
        $display("FAIL repeat k=%0d: got row=%0d col=%0d, want row=%0d col=0 (model %0d)",
                 k, sprite_row, sprite_col, exp_row, m_row);
      end
      if (k == 39) drive_btns(5'b0);
    end
    n_checks++;
    if (sprite_row !== 4'd4) begin
      n_errors++;
      $display("FAIL repeat_final: got row=%0d, want 4", sprite_row);
    end
    step(10);
  endtask

  task automatic test_simultaneous();
    int pulses, exp_row;
    drive_btns(5'b00101);
    for (int k = 1; k <= 10; k++) begin
      step(1);
      exp_row = (k >= 7) ? 3 : 4;
      n_checks++;
      if (sprite_row !== 4'(exp_row) || sprite_col !== 4'd0) begin
        n_errors++;
        $display("FAIL simul k=%0d: got (%0d,%0d), want (%0d,0)",
                 k, sprite_row, sprite_col, exp_row);
      end
      if (k == 8) drive_btns(5'b0);
    end
    step(12);
    pulses = 0;
    drive_btns(5'b10000);
    for (int k = 1; k <= 42; k++) begin
      step(1);
      if (fire === 1'b1) pulses++;
      n_checks++;
      if (fire !== (k == 7) || fire !== m_fire) begin
        n_errors++;
        $display("FAIL fire_timing k=%0d: got fire=%b, want %b", k, fire, (k == 7));
      end
      if (k == 30) drive_btns(5'b0);
    end
    n_checks++;
    if (pulses != 1) begin
      n_errors++;
      $display("FAIL fire_count: got %0d pulses, want 1", pulses);
    end
  endtask

  task automatic test_game_over();
    game_over = 1'b1;
    drive_btns(5'b11000);
    for (int k = 1; k <= 16; k++) begin
      step(1);
      n_checks++;
      if (fire !== 1'b0 || sprite_row !== 4'd3 || sprite_col !== 4'd0) begin
        n_errors++;
        $display("FAIL game_over k=%0d: got (%0d,%0d) fire=%b, want (3,0) fire=0",
                 k, sprite_row, sprite_col, fire);
      end
      if (k == 10) drive_btns(5'b0);
    end
    game_over = 1'b0;
    step(4);
    drive_btns(5'b01000);
    for (int k = 1; k <= 20; k++) begin
      step(1);
      n_checks++;
      if (sprite_col !== 4'd0 || sprite_col !== 4'(m_col) || fire !== 1'b0) begin
        n_errors++;
        $display("FAIL game_over_edge k=%0d: got col=%0d fire=%b, want col=0 fire=0",
                 k, sprite_col, fire);
      end
      if (k == 6) game_over = 1'b1;
      if (k == 7) game_over = 1'b0;
      if (k == 12) drive_btns(5'b0);
    end
    step(12);
  endtask

  task automatic test_reset_mid_hold();
    int exp_row;
    drive_btns(5'b00010);
    step(25);
    n_checks++;
    if (sprite_row !== 4'd4 || sprite_row !== 4'(m_row)) begin
      n_errors++;
      $display("FAIL mid_hold_pre: got row=%0d, want 4", sprite_row);
    end
    reset = 1'b1;
    step(2);
    n_checks++;
    if (sprite_row !== 4'd0 || sprite_col !== 4'd0 || fire !== 1'b0 || dut.state_q !== CurIdle)
    begin
      n_errors++;
      $display("FAIL mid_hold_reset: got (%0d,%0d) fire=%b state=%0d, want (0,0) 0 idle",
               sprite_row, sprite_col, fire, dut.state_q);
    end
    reset = 1'b0;
    for (int k = 1; k <= 9; k++) begin
      step(1);
      exp_row = (k >= 7) ? 1 : 0;
      n_checks++;
      if (sprite_row !== 4'(exp_row) || sprite_row !== 4'(m_row)) begin
        n_errors++;
        $display("FAIL post_reset_press k=%0d: got row=%0d, want %0d", k, sprite_row, exp_row);
      end
    end
    drive_btns(5'b0);
    step(12);
  endtask

  task automatic test_random();
    logic [4:0] v;
    v = '0;
    for (int n = 0; n < 1500; n++) begin
      for (int b = 0; b < 5; b++) if ($urandom_range(0, 11) == 0) v[b] = ~v[b];
      if ($urandom_range(0, 79) == 0) game_over = ~game_over;
      drive_btns(v);
      step(1);
      n_checks++;
      if (sprite_row !== 4'(m_row) || sprite_col !== 4'(m_col) || fire !== m_fire ||
          sprite_row > 4'd9 || sprite_col > 4'd9) begin
        n_errors++;
        $display("FAIL random n=%0d: got (%0d,%0d) fire=%b, want (%0d,%0d) fire=%b",
                 n, sprite_row, sprite_col, fire, m_row, m_col, m_fire);
      end
    end
    game_over = 1'b0;
    drive_btns(5'b0);
    step(12);
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_bounce();
    test_wrap();
    test_repeat();
    test_simultaneous();
    test_game_over();
    test_reset_mid_hold();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
